// File: rtl/accumulator16bit.sv
// Handshaked accumulator: LOAD/ADD/SUB/CLEAR with carry, borrow and signed-overflow flags.
// One operation is accepted in IDLE, executed in EXEC, and its result is held in HOLD until consumed.
module accumulator16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             outc,
    output logic             borrow,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             outc_reg, outc_next;
    logic             borrow_reg, borrow_next;
    logic             overflow_reg, overflow_next;
    logic             sticky_reg, sticky_next;
    logic [7:0]       count_reg, count_next;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand and op are only sampled on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg      <= OP_LOAD;
            operand_reg <= '0;
        end else if (state_reg == IDLE && in_valid) begin
            op_reg      <= op;
            operand_reg <= operand;
        end
    end

    // The extra top bit of the subtraction is the unsigned borrow.
    assign sum_ext  = {1'b0, acc_reg} + {1'b0, operand_reg};
    assign diff_ext = {1'b0, acc_reg} - {1'b0, operand_reg};
    assign add_ovf  = (acc_reg[WIDTH-1] == operand_reg[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != acc_reg[WIDTH-1]);
    assign sub_ovf  = (acc_reg[WIDTH-1] != operand_reg[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != acc_reg[WIDTH-1]);

    always_comb begin
        acc_next      = acc_reg;
        outc_next     = outc_reg;
        borrow_next   = borrow_reg;
        overflow_next = overflow_reg;
        sticky_next   = sticky_reg;
        count_next    = count_reg;
        if (state_reg == EXEC) begin
            case (op_reg)
                OP_ADD: begin
                    acc_next      = sum_ext[WIDTH-1:0];
                    outc_next     = sum_ext[WIDTH];
                    borrow_next   = 1'b0;
                    overflow_next = add_ovf;
                    sticky_next   = sticky_reg | add_ovf;
                    count_next    = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
                end
                OP_SUB: begin
                    acc_next      = diff_ext[WIDTH-1:0];
                    outc_next     = 1'b0;
                    borrow_next   = diff_ext[WIDTH];
                    overflow_next = sub_ovf;
                    sticky_next   = sticky_reg | sub_ovf;
                    count_next    = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
                end
                default: begin
                    acc_next      = (op_reg == OP_CLEAR) ? '0 : operand_reg;
                    outc_next     = 1'b0;
                    borrow_next   = 1'b0;
                    overflow_next = 1'b0;
                    sticky_next   = 1'b0;
                    count_next    = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg      <= '0;
            outc_reg     <= 1'b0;
            borrow_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            sticky_reg   <= 1'b0;
            count_reg    <= 8'd0;
        end else begin
            acc_reg      <= acc_next;
            outc_reg     <= outc_next;
            borrow_reg   <= borrow_next;
            overflow_reg <= overflow_next;
            sticky_reg   <= sticky_next;
            count_reg    <= count_next;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == HOLD);
    assign acc        = acc_reg;
    assign outc       = outc_reg;
    assign borrow     = borrow_reg;
    assign overflow   = overflow_reg;
    assign ovf_sticky = sticky_reg;
    assign op_count   = count_reg;

endmodule

// File: doc/accumulator16bit.md
ACCUMULATOR16BIT -- requirements
Module: accumulator16bit

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, datapath and accumulator width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand/op presented.
REQ-005 SHALL have port: in_ready  output  1  block accepts operand this cycle.
REQ-006 SHALL have port: operand  input  WIDTH  second adder-subtractor operand.
REQ-007 SHALL have port: op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-008 SHALL have port: out_valid  output  1  result and flags valid.
REQ-009 SHALL have port: out_ready  input  1  downstream consumes result.
REQ-010 SHALL have port: acc  output  WIDTH  accumulator value (registered).
REQ-011 SHALL have ports: outc, borrow, overflow  output  1 each  flags of last operation.
REQ-012 SHALL have port: ovf_sticky  output  1  OR of overflow since last LOAD/CLEAR.
REQ-013 SHALL have port: op_count  output  8  operations completed since last LOAD/CLEAR.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-015 SHALL assert in_ready only in IDLE; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-016 SHALL on transfer capture operand and op into internal registers and move IDLE->EXEC.
REQ-017 SHALL in EXEC compute the result from the accumulator and the captured operand, update acc and flags on that edge, and move EXEC->HOLD.
REQ-018 SHALL assert out_valid only in HOLD; HOLD->IDLE when out_ready is high, otherwise stay in HOLD with acc and flags stable.
REQ-019 SHALL give latency of 2 clocks from transfer edge to out_valid high; back-to-back throughput of one operation per 3 clocks when out_ready is held high.
REQ-020 SHALL for ADD set acc = (acc + operand) mod 2^WIDTH, outc = unsigned carry-out, borrow = 0.
REQ-021 SHALL for SUB set acc = (acc - operand) mod 2^WIDTH, borrow = 1 iff acc < operand unsigned, outc = 0.
REQ-022 SHALL for ADD/SUB set overflow = two's-complement signed overflow (operand signs per op agree, result sign differs).
REQ-023 SHALL for LOAD set acc = operand, for CLEAR set acc = 0; both clear outc, borrow, overflow, ovf_sticky and set op_count = 0.
REQ-024 SHALL for ADD/SUB set ovf_sticky |= overflow and increment op_count, saturating at 255 (no wrap).
REQ-025 SHALL ignore operand, op and in_valid changes outside IDLE; in_valid held high in HOLD is accepted only after return to IDLE.
REQ-026 SHALL keep acc stable except on the EXEC edge or reset.

Reset
REQ-027 SHALL on reset high immediately (asynchronously) force state IDLE, acc = 0, outc = borrow = overflow = ovf_sticky = 0, op_count = 0, out_valid = 0.
REQ-028 SHALL abandon any operation in progress when reset is asserted in EXEC or HOLD; no result is delivered for it.
REQ-029 SHALL assert in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: reset; LOAD 29, ADD 3 -> acc = 32, outc = 0, overflow = 0, op_count = 1, out_valid 2 clocks after each transfer.
REQ-031 SHALL cover: LOAD 21, SUB 83 -> acc = 65474 (0xFFC2), borrow = 1, overflow = 0.
REQ-032 SHALL cover: LOAD 32400, ADD 32200 -> acc = 64600, overflow = 1, ovf_sticky = 1; then SUB 1 -> overflow = 0, ovf_sticky stays 1; then CLEAR -> acc = 0, ovf_sticky = 0, op_count = 0.
REQ-033 SHALL cover: LOAD 65534, ADD 65100 -> acc = 65098, outc = 1, overflow = 0.
REQ-034 SHALL cover: out_ready held low 5 cycles in HOLD -> out_valid, acc, flags unchanged and in_ready = 0 throughout; in_valid high meanwhile is not accepted until the cycle after out_ready is high.
REQ-035 SHALL cover: reset asserted mid-EXEC after LOAD 7, ADD 1 -> acc = 0, out_valid = 0, in_ready = 1 after release; 300 consecutive ADD 1 ops -> op_count saturates at 255, acc = 300 + load value.
